// File: rtl/rnn_fp_pkg.sv
// Shared package for the RNN FP32 datapath blocks.
// Holds the FP32 word type, the FP32 zero constant and the state encoding
// used by the dual-lane accumulation sequencer.
package rnn_fp_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        ISSUE,
        WAIT_ADD,
        OUTPUT
    } acc_state_t;

endpackage

// File: rtl/float_acc_dual_ctrl.sv
// Dual-lane FP32 accumulation sequencer.
// Takes a stream of element pairs (x1, x2) and reduces each lane to a sum by
// driving an external dual float adder one operation at a time, writing the
// adder results back into the two accumulators.  After len pairs the two sums
// are presented on a valid/ready output.  No FP arithmetic is done here.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, len, busy         reduction control (len captured on start in IDLE)
//   in_valid/in_ready        element pair handshake, in_x1 / in_x2 payload
//   add_valid/add_ready      operand handshake to the dual adder
//   add_a1/add_b1/add_a2/add_b2  registered adder operands (a=acc, b=element)
//   add_done, add_res1/2     adder completion pulse and results
//   out_valid/out_ready      sums handshake, sum1 / sum2 payload
//   err                      sticky: adder result arrived when none was pending
module float_acc_dual_ctrl
    import rnn_fp_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    output logic             add_valid,
    input  logic             add_ready,
    output logic [31:0]      add_a1,
    output logic [31:0]      add_b1,
    output logic [31:0]      add_a2,
    output logic [31:0]      add_b2,
    input  logic             add_done,
    input  logic [31:0]      add_res1,
    input  logic [31:0]      add_res2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      sum1,
    output logic [31:0]      sum2,
    output logic             err
);

    acc_state_t       state;
    acc_state_t       state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_inc;
    fp32_t            acc1;
    fp32_t            acc2;

    // count never wraps because len is at most 2^LEN_W-1
    assign count_inc = count + LEN_W'(1);

    // Sums track the accumulators directly; they are only meaningful while
    // out_valid is high, and read as zero after reset.
    assign sum1 = acc1;
    assign sum2 = acc2;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        in_ready   = 1'b0;
        add_valid  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? OUTPUT : WAIT_IN;
                end
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (count == '0) begin
                        state_next = (len_q == LEN_W'(1)) ? OUTPUT : WAIT_IN;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                add_valid = 1'b1;
                if (add_ready) begin
                    state_next = WAIT_ADD;
                end
            end
            WAIT_ADD: begin
                if (add_done) begin
                    state_next = (count_inc == len_q) ? OUTPUT : WAIT_IN;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: length/count capture, accumulators, operand registers, err.
    // The first element of a reduction is loaded straight into the
    // accumulators so only len-1 adder operations are needed.  Operands are
    // captured at the element handshake, so they stay stable throughout ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            count  <= '0;
            acc1   <= FP32_ZERO;
            acc2   <= FP32_ZERO;
            add_a1 <= FP32_ZERO;
            add_b1 <= FP32_ZERO;
            add_a2 <= FP32_ZERO;
            add_b2 <= FP32_ZERO;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        count <= '0;
                        err   <= 1'b0;
                        if (len == '0) begin
                            acc1 <= FP32_ZERO;
                            acc2 <= FP32_ZERO;
                        end
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        if (count == '0) begin
                            acc1  <= in_x1;
                            acc2  <= in_x2;
                            count <= LEN_W'(1);
                        end else begin
                            add_a1 <= acc1;
                            add_b1 <= in_x1;
                            add_a2 <= acc2;
                            add_b2 <= in_x2;
                        end
                    end
                end
                WAIT_ADD: begin
                    if (add_done) begin
                        acc1  <= add_res1;
                        acc2  <= add_res2;
                        count <= count_inc;
                    end
                end
                default: begin
                end
            endcase
            // A result with no pending operation is discarded and flagged;
            // flagging takes priority over a same-cycle start clear.
            if (add_done && (state != WAIT_ADD)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/float_acc_dual_ctrl.md
Name: float_acc_dual_ctrl

Overview:
- Dual-lane FP32 accumulation sequencer that sits directly upstream of the dual float adder and also consumes its results.
- Accepts a stream of element pairs (x1, x2) and feeds the adder with (acc1, x1) and (acc2, x2), one operation at a time.
- Writes each adder result back into the accumulators.
- After LEN pairs, presents the two sums on a valid/ready output (e.g. RNN gate dot-product reduction).

Parameters:
- LEN_W, 8, width of the element-count input; max reduction length is 2^LEN_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin a reduction; sampled only in IDLE
- len  in  LEN_W  number of element pairs; captured on start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  element pair valid
- in_ready  out  1  element pair accepted when in_valid&in_ready
- in_x1  in  32  lane-1 element, FP32
- in_x2  in  32  lane-2 element, FP32
- add_valid  out  1  operands valid to dual adder
- add_ready  in  1  dual adder ready; operation issued when add_valid&add_ready
- add_a1, add_b1, add_a2, add_b2  out  32 each  adder operands (a=accumulator, b=element)
- add_done  in  1  one-cycle pulse, both results valid
- add_res1, add_res2  in  32 each  adder results
- out_valid  out  1  sums valid
- out_ready  in  1  sums consumed when out_valid&out_ready
- sum1, sum2  out  32 each  final sums
- err  out  1  sticky: add_done seen outside WAIT_ADD

Behaviour:
- Reset values: all outputs 0, acc1/acc2=0, count=0, state=IDLE, err=0. An asserted rst aborts any operation immediately; no partial result is emitted.
- States: IDLE, WAIT_IN, ISSUE, WAIT_ADD, OUTPUT.
- IDLE:
  - start=1 captures len, clears count and err.
  - len==0: acc1=acc2=32'h0000_0000, go to OUTPUT.
  - Otherwise go to WAIT_IN.
  - start is ignored in every other state.
- WAIT_IN:
  - in_ready=1.
  - On handshake with count==0: load acc1=in_x1, acc2=in_x2 directly (first-element bypass, no adder op), count=1, then go to OUTPUT if len==1, else stay in WAIT_IN.
  - On handshake with count>0: latch x1/x2, go to ISSUE.
- ISSUE:
  - add_valid=1; operands are registered: a1=acc1, b1=x1, a2=acc2, b2=x2.
  - Operands held stable until add_ready; on handshake go to WAIT_ADD.
  - Exactly one issue per element.
- WAIT_ADD:
  - add_valid=0, in_ready=0.
  - On add_done: acc1<=add_res1, acc2<=add_res2, count++.
  - Go to OUTPUT if the new count==len, else to WAIT_IN.
  - No timeout.
- OUTPUT:
  - out_valid=1, sum1=acc1, sum2=acc2, held stable until out_ready.
  - On handshake go to IDLE.
  - A start in the same cycle as the handshake is ignored (IDLE must be reached first).
- err:
  - Set by add_done in any state other than WAIT_ADD.
  - Cleared only by rst or by an accepted start.
  - The stray result is discarded and does not change acc or state.
- Latency:
  - start to in_ready=1: 1 cycle.
  - in handshake to add_valid: 1 cycle.
  - add_done to in_ready (more elements) or out_valid (last): 1 cycle.
  - len==0: out_valid 1 cycle after start.
- Adder operations per reduction = max(len-1, 0). No FP arithmetic is performed locally.
- Count arithmetic is LEN_W bits; since len ≤ 2^LEN_W-1, it never wraps.

Decomposition:
- Shared package rnn_fp_pkg holds:
  - typedef fp32_t (logic [31:0]);
  - constant FP32_ZERO = 32'h0000_0000;
  - FSM enum acc_state_t {IDLE, WAIT_IN, ISSUE, WAIT_ADD, OUTPUT}.
- Single flat module, no sub-module; it is instantiated beside the dual adder in the parent.

Test Plan:
- len=3, x1 = 3F800000, 40000000, 40400000; x2 = 3F000000 ×3; adder model latency 4 → exactly 2 add issues; sum1=40C00000 (6.0), sum2=3FC00000 (1.5).
- len=0 → out_valid asserted 1 cycle after start; sum1=sum2=00000000; no in_ready, no add_valid.
- len=1, x1=BF800000, x2=3F800000 → sum1=BF800000, sum2=3F800000; add_valid never asserted.
- len=2, add_ready held low 5 cycles, out_ready held low 3 cycles → operands stable throughout; one issue only; out_valid and sums held; sum1 = x1a + x1b.
- rst pulsed while in WAIT_ADD → all outputs 0 next edge; then a stray add_done in IDLE → err=1 with acc unchanged; next start → err=0.
- start pulsed while busy, and again coincident with the OUTPUT handshake → both ignored; len is not recaptured.
